// File: rtl/aud_pkg.sv
// Shared constants and state types for the audio mode controller.
package aud_pkg;

   localparam int unsigned AW = 20;
   localparam int unsigned DW = 16;

   typedef enum logic [2:0] {
      M_IDLE       = 3'd0,
      M_RECORD     = 3'd1,
      M_REC_PAUSE  = 3'd2,
      M_PLAY       = 3'd3,
      M_PLAY_PAUSE = 3'd4
   } aud_mode_e;

   typedef enum logic [1:0] {
      P_IDLE   = 2'd0,
      P_ACCESS = 2'd1,
      P_DONE   = 2'd2
   } port_state_e;

endpackage

// File: rtl/aud_sram_port.sv
// Single-port SRAM access sequencer: latch request, one strobe cycle, one ack cycle.
module aud_sram_port
   import aud_pkg::*;
(
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_req,
   input  logic          i_wr,
   input  logic [AW-1:0] i_addr,
   input  logic [DW-1:0] i_wdata,
   output logic [AW-1:0] o_sram_addr,
   output logic [DW-1:0] o_sram_wdata,
   input  logic [DW-1:0] i_sram_rdata,
   output logic          o_sram_we_n,
   output logic          o_sram_oe_n,
   output logic          o_wr,
   output logic          o_last,
   output logic          o_wr_ack,
   output logic          o_rd_ack,
   output logic [DW-1:0] o_rd_data
);

   port_state_e state;
   port_state_e state_nxt;

   // State register.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) state <= P_IDLE;
      else          state <= state_nxt;
   end

   // Access latch on acceptance and read-data capture at the end of the strobe cycle.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         o_sram_addr  <= '0;
         o_sram_wdata <= '0;
         o_wr         <= 1'b0;
         o_rd_data    <= '0;
      end else begin
         if (state == P_IDLE && i_req) begin
            o_sram_addr  <= i_addr;
            o_sram_wdata <= i_wdata;
            o_wr         <= i_wr;
         end
         if (state == P_ACCESS && !o_wr) o_rd_data <= i_sram_rdata;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         P_IDLE:   if (i_req) state_nxt = P_ACCESS;
         P_ACCESS: state_nxt = P_DONE;
         P_DONE:   state_nxt = P_IDLE;
         default:  state_nxt = P_IDLE;
      endcase
   end

   // Strobes and acks decoded from state so reset releases them on the next edge.
   always_comb begin
      o_sram_we_n = !(state == P_ACCESS && o_wr);
      o_sram_oe_n = !(state == P_ACCESS && !o_wr);
      o_last      = (state == P_ACCESS);
      o_wr_ack    = (state == P_DONE) && o_wr;
      o_rd_ack    = (state == P_DONE) && !o_wr;
   end

endmodule

// File: rtl/aud_ctrl.sv
// Audio record/playback mode controller and SRAM arbiter.
// AUD_CTRL_AUTOSTOP_EN: playback stops at the recording end instead of looping
// (and o_play_restart is not present).
module aud_ctrl
   import aud_pkg::*;
(
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_key_rec,
   input  logic          i_key_play,
   input  logic          i_key_pause,
   input  logic          i_key_stop,
   output logic          o_rec_start,
   output logic          o_rec_pause,
   output logic          o_rec_stop,
   output logic          o_play_start,
   output logic          o_play_pause,
   output logic          o_play_stop,
`ifndef AUD_CTRL_AUTOSTOP_EN
   output logic          o_play_restart,
`endif
   input  logic          i_rec_req,
   input  logic [AW-1:0] i_rec_addr,
   input  logic [DW-1:0] i_rec_data,
   output logic          o_rec_ack,
   input  logic          i_play_req,
   input  logic [AW-1:0] i_play_addr,
   output logic [DW-1:0] o_play_data,
   output logic          o_play_ack,
   output logic [AW-1:0] o_sram_addr,
   output logic [DW-1:0] o_sram_wdata,
   input  logic [DW-1:0] i_sram_rdata,
   output logic          o_sram_we_n,
   output logic          o_sram_oe_n,
   output logic [2:0]    o_mode,
   output logic [AW-1:0] o_rec_end,
   output logic          o_have_data
);

   aud_mode_e     mode;
   aud_mode_e     mode_nxt;
   logic          rec_start_nxt, rec_pause_nxt, rec_stop_nxt;
   logic          play_start_nxt, play_pause_nxt, play_stop_nxt;
`ifndef AUD_CTRL_AUTOSTOP_EN
   logic          restart_nxt;
`endif
   logic [AW-1:0] rec_end_nxt;
   logic          have_nxt;
   logic          k_stop, k_pause, k_rec, k_play;
   logic          port_req, port_wr, port_last, acc_wr;
   logic          wr_fin, rd_fin;

   aud_sram_port u_port (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_req        (port_req),
      .i_wr         (port_wr),
      .i_addr       (port_wr ? i_rec_addr : i_play_addr),
      .i_wdata      (i_rec_data),
      .o_sram_addr  (o_sram_addr),
      .o_sram_wdata (o_sram_wdata),
      .i_sram_rdata (i_sram_rdata),
      .o_sram_we_n  (o_sram_we_n),
      .o_sram_oe_n  (o_sram_oe_n),
      .o_wr         (acc_wr),
      .o_last       (port_last),
      .o_wr_ack     (o_rec_ack),
      .o_rd_ack     (o_play_ack),
      .o_rd_data    (o_play_data)
   );

   // Mode, command pulses and recording-end registers.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         mode         <= M_IDLE;
         o_rec_start  <= 1'b0;
         o_rec_pause  <= 1'b0;
         o_rec_stop   <= 1'b0;
         o_play_start <= 1'b0;
         o_play_pause <= 1'b0;
         o_play_stop  <= 1'b0;
`ifndef AUD_CTRL_AUTOSTOP_EN
         o_play_restart <= 1'b0;
`endif
         o_rec_end    <= '0;
         o_have_data  <= 1'b0;
      end else begin
         mode         <= mode_nxt;
         o_rec_start  <= rec_start_nxt;
         o_rec_pause  <= rec_pause_nxt;
         o_rec_stop   <= rec_stop_nxt;
         o_play_start <= play_start_nxt;
         o_play_pause <= play_pause_nxt;
         o_play_stop  <= play_stop_nxt;
`ifndef AUD_CTRL_AUTOSTOP_EN
         o_play_restart <= restart_nxt;
`endif
         o_rec_end    <= rec_end_nxt;
         o_have_data  <= have_nxt;
      end
   end

   // Key decode and mode transitions; access-completion events override key results.
   always_comb begin
      k_stop  = i_key_stop;
      k_pause = i_key_pause & ~i_key_stop;
      k_rec   = i_key_rec & ~i_key_pause & ~i_key_stop;
      k_play  = i_key_play & ~i_key_rec & ~i_key_pause & ~i_key_stop;

      mode_nxt       = mode;
      rec_start_nxt  = 1'b0;
      rec_pause_nxt  = 1'b0;
      rec_stop_nxt   = 1'b0;
      play_start_nxt = 1'b0;
      play_pause_nxt = 1'b0;
      play_stop_nxt  = 1'b0;
`ifndef AUD_CTRL_AUTOSTOP_EN
      restart_nxt    = 1'b0;
`endif
      rec_end_nxt    = o_rec_end;
      have_nxt       = o_have_data;

      case (mode)
         M_IDLE: begin
            if (k_rec) begin
               mode_nxt      = M_RECORD;
               rec_start_nxt = 1'b1;
               rec_end_nxt   = '0;
               have_nxt      = 1'b0;
            end else if (k_play && o_have_data) begin
               mode_nxt       = M_PLAY;
               play_start_nxt = 1'b1;
            end
         end
         M_RECORD: begin
            if (k_stop) begin
               mode_nxt     = M_IDLE;
               rec_stop_nxt = 1'b1;
            end else if (k_pause) begin
               mode_nxt      = M_REC_PAUSE;
               rec_pause_nxt = 1'b1;
            end
         end
         M_REC_PAUSE: begin
            if (k_stop) begin
               mode_nxt     = M_IDLE;
               rec_stop_nxt = 1'b1;
            end else if (k_pause || k_rec) begin
               mode_nxt      = M_RECORD;
               rec_start_nxt = 1'b1;
            end
         end
         M_PLAY: begin
            if (k_stop) begin
               mode_nxt      = M_IDLE;
               play_stop_nxt = 1'b1;
            end else if (k_pause) begin
               mode_nxt       = M_PLAY_PAUSE;
               play_pause_nxt = 1'b1;
            end
         end
         M_PLAY_PAUSE: begin
            if (k_stop) begin
               mode_nxt      = M_IDLE;
               play_stop_nxt = 1'b1;
            end else if (k_pause || k_play) begin
               mode_nxt       = M_PLAY;
               play_start_nxt = 1'b1;
            end
         end
         default: mode_nxt = M_IDLE;
      endcase

      // Completion is decided in the strobe cycle so its effects register into the ack cycle.
      if (wr_fin) begin
         rec_end_nxt = o_sram_addr;
         have_nxt    = 1'b1;
         if (&o_sram_addr) begin
            mode_nxt     = M_IDLE;
            rec_stop_nxt = 1'b1;
         end
      end
      if (rd_fin && (o_sram_addr == o_rec_end)) begin
`ifdef AUD_CTRL_AUTOSTOP_EN
         mode_nxt      = M_IDLE;
         play_stop_nxt = 1'b1;
`else
         restart_nxt   = 1'b1;
`endif
      end
   end

   // Ownership gating and status outputs.
   always_comb begin
      port_req = ((mode == M_RECORD) && i_rec_req) || ((mode == M_PLAY) && i_play_req);
      port_wr  = (mode == M_RECORD);
      wr_fin   = port_last && acc_wr;
      rd_fin   = port_last && !acc_wr;
      o_mode   = mode;
   end

endmodule

// File: tb/tb_aud_ctrl.sv
// Scoreboard bench for aud_ctrl: behavioural mode/recording model plus SRAM model.
module tb_aud_ctrl;
   import aud_pkg::*;

   localparam int RS = 6, RP = 5, RT = 4, PS = 3, PP = 2, PT = 1, RR = 0;

   typedef struct {
      bit              wr;
      logic [AW-1:0]   a;
      logic [DW-1:0]   d;
      int unsigned     cyc;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic          key_rec, key_play, key_pause, key_stop;
   logic          rec_start, rec_pause, rec_stop, play_start, play_pause, play_stop;
   logic          play_restart;
   logic          rec_req, rec_ack, play_req, play_ack;
   logic [AW-1:0] rec_addr, play_addr, sram_addr, rec_end;
   logic [DW-1:0] rec_data, play_data, sram_wdata, sram_rdata;
   logic          we_n, oe_n, have_data;
   logic [2:0]    mode;
   logic [6:0]    pv;

   int unsigned   checks = 0, fails = 0, cyc = 0;
   int unsigned   exp_cnt [7];
   int unsigned   dut_cnt [7];
   bit            mon_en = 1'b0;
   exp_t          sb [$];

   logic [2:0]    m_mode;
   logic [AW-1:0] m_end;
   bit            m_have;
   logic [DW-1:0] m_mem  [logic [AW-1:0]];
   logic [DW-1:0] sram   [logic [AW-1:0]];

   aud_ctrl dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_key_rec      (key_rec),
      .i_key_play     (key_play),
      .i_key_pause    (key_pause),
      .i_key_stop     (key_stop),
      .o_rec_start    (rec_start),
      .o_rec_pause    (rec_pause),
      .o_rec_stop     (rec_stop),
      .o_play_start   (play_start),
      .o_play_pause   (play_pause),
      .o_play_stop    (play_stop),
`ifndef AUD_CTRL_AUTOSTOP_EN
      .o_play_restart (play_restart),
`endif
      .i_rec_req      (rec_req),
      .i_rec_addr     (rec_addr),
      .i_rec_data     (rec_data),
      .o_rec_ack      (rec_ack),
      .i_play_req     (play_req),
      .i_play_addr    (play_addr),
      .o_play_data    (play_data),
      .o_play_ack     (play_ack),
      .o_sram_addr    (sram_addr),
      .o_sram_wdata   (sram_wdata),
      .i_sram_rdata   (sram_rdata),
      .o_sram_we_n    (we_n),
      .o_sram_oe_n    (oe_n),
      .o_mode         (mode),
      .o_rec_end      (rec_end),
      .o_have_data    (have_data)
   );

`ifdef AUD_CTRL_AUTOSTOP_EN
   assign play_restart = 1'b0;
`endif

   assign pv = {rec_start, rec_pause, rec_stop, play_start, play_pause, play_stop, play_restart};

   always @(posedge clk) cyc <= cyc + 1;

   // SRAM model: write on strobe, read data presented shortly after the edge.
   always @(posedge clk) begin
      if (we_n == 1'b0) sram[sram_addr] = sram_wdata;
   end
   always @(posedge clk) begin
      #2;
      if (oe_n == 1'b0 && sram.exists(sram_addr)) sram_rdata = sram[sram_addr];
      else sram_rdata = '0;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Monitor: mode every cycle, pulse tally, ack scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         chk("mode", 32'(mode), 32'(m_mode));
         for (int b = 0; b < 7; b++) if (pv[b]) dut_cnt[b]++;
         if (rec_ack || play_ack) begin
            if (sb.size() == 0) begin
               checks++;
               fails++;
               $display("FAIL unexpected_ack: got rec_ack=%0b play_ack=%0b expected none at cycle %0d",
                        rec_ack, play_ack, cyc);
            end else begin
               e = sb.pop_front();
               chk("ack_kind", 32'({rec_ack, play_ack}), e.wr ? 32'd2 : 32'd1);
               chk("ack_latency", 32'(cyc), 32'(e.cyc));
               if (e.wr) begin
                  chk("rec_end_at_ack", 32'(rec_end), 32'(e.a));
                  chk("have_at_ack", 32'(have_data), 32'd1);
               end else begin
                  chk("play_data", 32'(play_data), 32'(e.d));
               end
            end
         end
      end
   end

   // Reference mode model: highest-priority key only, then per-mode rules.
   task automatic apply_key(input logic [3:0] k, output int idx);
      int sel;
      idx = -1;
      sel = k[3] ? 3 : k[2] ? 2 : k[1] ? 1 : k[0] ? 0 : -1;   // stop, pause, rec, play
      case (m_mode)
         3'd0: if (sel == 1) begin m_mode = 3'd1; idx = RS; m_end = '0; m_have = 1'b0; end
               else if (sel == 0 && m_have) begin m_mode = 3'd3; idx = PS; end
         3'd1: if (sel == 3) begin m_mode = 3'd0; idx = RT; end
               else if (sel == 2) begin m_mode = 3'd2; idx = RP; end
         3'd2: if (sel == 3) begin m_mode = 3'd0; idx = RT; end
               else if (sel == 2 || sel == 1) begin m_mode = 3'd1; idx = RS; end
         3'd3: if (sel == 3) begin m_mode = 3'd0; idx = PT; end
               else if (sel == 2) begin m_mode = 3'd4; idx = PP; end
         3'd4: if (sel == 3) begin m_mode = 3'd0; idx = PT; end
               else if (sel == 2 || sel == 0) begin m_mode = 3'd3; idx = PS; end
         default: ;
      endcase
      if (idx >= 0) exp_cnt[idx]++;
   endtask

   task automatic press(input logic [3:0] k);
      int idx;
      logic [6:0] oh;
      @(posedge clk); #1;
      {key_stop, key_pause, key_rec, key_play} = k;
      @(posedge clk); #1;
      {key_stop, key_pause, key_rec, key_play} = '0;
      apply_key(k, idx);
      oh = (idx < 0) ? 7'd0 : 7'(1 << idx);
      chk("cmd_pulse", 32'(pv), 32'(oh));
      chk("rec_end", 32'(rec_end), 32'(m_end));
      chk("have_data", 32'(have_data), 32'(m_have));
      @(posedge clk); #1;
      chk("pulse_width", 32'(pv), 32'd0);
   endtask

   task automatic access(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input bit stop_mid, input bit expect_ack);
      exp_t e;
      bit   got;
      int   idx;
      @(posedge clk); #1;
      if (wr) begin rec_req = 1'b1; rec_addr = a; rec_data = d; end
      else begin play_req = 1'b1; play_addr = a; end
      if (expect_ack) begin
         e.wr  = wr;
         e.a   = a;
         e.d   = wr ? d : (m_mem.exists(a) ? m_mem[a] : '0);
         e.cyc = cyc + 2;
         sb.push_back(e);
      end
      got = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (stop_mid && i == 0) key_stop = 1'b1;
         if (stop_mid && i == 1) begin
            key_stop = 1'b0;
            apply_key(4'b1000, idx);
            chk("stop_mid_pulse", 32'(rec_stop), 32'd1);
         end
         if (!expect_ack) begin
            chk("unowned_we_n", 32'(we_n), 32'd1);
            chk("unowned_oe_n", 32'(oe_n), 32'd1);
         end
         if (wr ? rec_ack : play_ack) begin
            got = 1'b1;
            if (wr) begin
               m_mem[a] = d;
               m_end    = a;
               m_have   = 1'b1;
               if (a == {AW{1'b1}}) begin
                  chk("full_rec_stop", 32'(rec_stop), 32'd1);
                  m_mode = 3'd0;
                  exp_cnt[RT]++;
               end
            end else if (a == m_end) begin
`ifdef AUD_CTRL_AUTOSTOP_EN
               chk("autostop", 32'(play_stop), 32'd1);
               m_mode = 3'd0;
               exp_cnt[PT]++;
`else
               chk("restart", 32'(play_restart), 32'd1);
               exp_cnt[RR]++;
`endif
            end
            break;
         end
      end
      rec_req  = 1'b0;
      play_req = 1'b0;
      if (expect_ack && !got) begin
         checks++;
         fails++;
         $display("FAIL ack_timeout: got no ack expected ack for addr %0h at cycle %0d", a, cyc);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish by 1ms");
      $fatal(1);
   end

   initial begin
      int n;
      logic [3:0] k;
      bit wr;
      logic [AW-1:0] a;
      for (int b = 0; b < 7; b++) begin exp_cnt[b] = 0; dut_cnt[b] = 0; end
      rst_n = 1'b0;
      {key_stop, key_pause, key_rec, key_play} = '0;
      rec_req = 1'b0; play_req = 1'b0;
      rec_addr = '0; play_addr = '0; rec_data = '0; sram_rdata = '0;
      m_mode = 3'd0; m_end = '0; m_have = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_mode", 32'(mode), 32'd0);
      chk("rst_strobes", 32'({we_n, oe_n}), 32'd3);
      chk("rst_pulses", 32'(pv), 32'd0);
      chk("rst_acks", 32'({rec_ack, play_ack}), 32'd0);
      chk("rst_sram_addr", 32'(sram_addr), 32'd0);
      chk("rst_sram_wdata", 32'(sram_wdata), 32'd0);
      chk("rst_play_data", 32'(play_data), 32'd0);
      chk("rst_rec_end", 32'(rec_end), 32'd0);
      chk("rst_have", 32'(have_data), 32'd0);
      rst_n  = 1'b1;
      mon_en = 1'b1;

      // Play with no recording is ignored; record three words.
      press(4'b0001);
      press(4'b0010);
      access(1'b1, 20'd0, 16'h1111, 1'b0, 1'b1);
      access(1'b1, 20'd1, 16'h2222, 1'b0, 1'b1);
      access(1'b1, 20'd2, 16'h3333, 1'b0, 1'b1);
      press(4'b1000);
      chk("rec_end_after_rec", 32'(rec_end), 32'd2);
      chk("have_after_rec", 32'(have_data), 32'd1);

      // Play back; the final read hits the recording end.
      press(4'b0001);
      access(1'b0, 20'd0, '0, 1'b0, 1'b1);
      access(1'b0, 20'd1, '0, 1'b0, 1'b1);
      access(1'b0, 20'd2, '0, 1'b0, 1'b1);
      press(4'b1000);

      // Ownership, key priority, stop during an access, full SRAM.
      press(4'b0010);
      access(1'b0, 20'd1, '0, 1'b0, 1'b0);
      press(4'b1100);
      press(4'b0010);
      access(1'b1, 20'd5, 16'hA5A5, 1'b1, 1'b1);
      press(4'b0010);
      access(1'b1, 20'hFFFFF, 16'h5A5A, 1'b0, 1'b1);

      // Reset during a write discards it.
      press(4'b0010);
      @(posedge clk); #1;
      rec_req = 1'b1; rec_addr = 20'h00077; rec_data = 16'hBEEF;
      @(posedge clk); #1;
      chk("mid_we_low", 32'(we_n), 32'd0);
      rec_req = 1'b0;
      rst_n   = 1'b0;
      @(posedge clk); #1;
      m_mode = 3'd0; m_end = '0; m_have = 1'b0;
      rst_n  = 1'b1;
      chk("reset_mid_strobes", 32'({we_n, oe_n}), 32'd3);
      chk("reset_mid_have", 32'(have_data), 32'd0);
      repeat (4) @(posedge clk);
      #1;
      chk("reset_mid_no_ack", 32'(sb.size()), 32'd0);

      // Randomised recording and playback.
      n = 3 + int'($urandom_range(0, 4));
      press(4'b0010);
      for (int i = 0; i < n; i++) access(1'b1, AW'(i), 16'($urandom), 1'b0, 1'b1);
      press(4'b1000);
      press(4'b0001);
      for (int i = 0; i < n; i++) access(1'b0, AW'(i), '0, 1'b0, 1'b1);
      press(4'b1000);

      // Randomised key mixes and accesses from whichever mode the model is in.
      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(0, 3) == 0) begin
            wr = 1'($urandom_range(0, 1));
            a  = AW'($urandom_range(0, n - 1));
            access(wr, a, 16'($urandom), 1'b0, wr ? (m_mode == 3'd1) : (m_mode == 3'd3));
         end else begin
            k = 4'($urandom) & 4'($urandom);
            press(k);
         end
      end

      repeat (4) @(posedge clk);
      #1;
      for (int b = 0; b < 7; b++) chk("pulse_count", dut_cnt[b], exp_cnt[b]);
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule

// File: doc/aud_ctrl.md
# aud_ctrl

Mode controller and SRAM access scheduler for the audio record/playback path. Converts single-cycle key pulses into start/pause/stop commands for the recorder and player. Grants the shared 20-bit × 16-bit SRAM to whichever engine owns the current mode, and tracks the last recorded address so playback ends (or loops) at the recording boundary.

## Interface
- `AW`, 20: SRAM address width.
- `DW`, 16: SRAM data width.
---
- `i_clk`, in, 1: system clock. All logic is on its rising edge.
- `i_rst_n`, in, 1: reset, synchronous, active-low.
- `i_key_rec`, `i_key_play`, `i_key_pause`, `i_key_stop`, in, 1 each: debounced key pulses, one cycle wide.
- `o_rec_start`, `o_rec_pause`, `o_rec_stop`, out, 1 each: recorder command pulses.
- `o_play_start`, `o_play_pause`, `o_play_stop`, out, 1 each: player command pulses.
- `o_play_restart`, out, 1: pulse that restarts the player at address 0. Present only when looping is compiled in (see Configuration).
- `i_rec_req`, in, 1: recorder write request. Held high until `o_rec_ack`.
- `i_rec_addr`, in, AW: recorder write address.
- `i_rec_data`, in, DW: recorder write data.
- `o_rec_ack`, out, 1: write-complete pulse.
- `i_play_req`, in, 1: player read request. Held high until `o_play_ack`.
- `i_play_addr`, in, AW: player read address.
- `o_play_data`, out, DW: read data. Valid in the `o_play_ack` cycle; held until the next read completes.
- `o_play_ack`, out, 1: read-complete pulse.
- `o_sram_addr`, out, AW: SRAM address.
- `o_sram_wdata`, out, DW: SRAM write data.
- `i_sram_rdata`, in, DW: SRAM read data.
- `o_sram_we_n`, `o_sram_oe_n`, out, 1 each: SRAM strobes, active-low.
- `o_mode`, out, 3: current mode.
- `o_rec_end`, out, AW: last written address.
- `o_have_data`, out, 1: a recording exists.

## Operation
- Modes: IDLE=0, RECORD=1, REC_PAUSE=2, PLAY=3, PLAY_PAUSE=4.
- Key priority when keys arrive together: stop > pause > rec > play. Only the highest-priority key acts.
- IDLE:
  - rec → RECORD. Pulse `o_rec_start`, clear `o_rec_end` and `o_have_data`.
  - play → PLAY with `o_play_start`, only if `o_have_data`=1. Otherwise play is ignored.
  - pause and stop are ignored.
- RECORD:
  - pause → REC_PAUSE with `o_rec_pause`.
  - stop → IDLE with `o_rec_stop`.
  - rec and play are ignored.
- REC_PAUSE:
  - rec or pause → RECORD with `o_rec_start`.
  - stop → IDLE with `o_rec_stop`.
- PLAY and PLAY_PAUSE behave symmetrically, using the play pulses and the play key.
- Ownership: RECORD grants only `i_rec_req`; PLAY grants only `i_play_req`. Any other request is never acked.
- Port FSM P_IDLE → P_ACCESS → P_DONE → P_IDLE:
  - P_IDLE: if the owning request is high, register address and data (and direction) and go to P_ACCESS.
  - P_ACCESS: drive the strobe low: `o_sram_we_n`=0 for a write, `o_sram_oe_n`=0 for a read. `i_sram_rdata` is captured at the end of this cycle.
  - P_DONE: pulse the matching ack.
- A mode change during P_ACCESS or P_DONE does not abort the access; its ack is still delivered.
- Write ack:
  - `o_rec_end` ← written address, `o_have_data` ← 1.
  - If the written address is all ones (SRAM full): mode → IDLE and pulse `o_rec_stop` in the same cycle as the ack.
- Read ack at address == `o_rec_end`: end of recording is handled as described under Configuration.

## Timing
- Request high in cycle k while the port is in P_IDLE: strobe low in cycle k+1, ack in cycle k+2.
- The next request is sampled no earlier than cycle k+3. Maximum throughput is one access per 3 cycles.
- Key pulse in cycle k: the mode and the command pulse both change in cycle k+1.
- All command pulses and acks are exactly one cycle wide.
- Reset values:
  - mode IDLE, port P_IDLE.
  - all pulses 0, `o_sram_we_n`=`o_sram_oe_n`=1.
  - `o_sram_addr`, `o_sram_wdata`, `o_play_data`, `o_rec_end` = 0; `o_have_data`=0.
- Reset asserted mid-access discards the access: no ack is issued and the strobes return high on the next edge.

## Configuration
- `AUD_CTRL_AUTOSTOP_EN` defined: a read ack at `o_rec_end` sends the mode to IDLE and pulses `o_play_stop` in the ack cycle. `o_play_restart` is absent.
- `AUD_CTRL_AUTOSTOP_EN` undefined: the same event pulses `o_play_restart` and the mode stays PLAY, so playback loops.

## Structure
- Package `aud_pkg` holds:
  - the `AW` and `DW` constants;
  - the `aud_mode_e` enum for the five modes;
  - the `port_state_e` enum for the port FSM.
- Sub-module `aud_sram_port` implements the three-state access FSM, the strobes, and the data capture. `aud_ctrl` holds the mode FSM, the key decode, ownership gating, and end tracking.

## Test plan
- Reset, then rec pulse → `o_rec_start` pulse and mode 1. Three write requests at addresses 0, 1, 2 with data 16'h1111, 16'h2222, 16'h3333 → each acked 2 cycles after acceptance; `o_rec_end`=2, `o_have_data`=1.
- Stop, then play → `o_play_start`. Reads at 0..2 → `o_play_data` = 1111, 2222, 3333. With AUTOSTOP: at address 2, `o_play_stop` pulses and mode returns to 0. Without AUTOSTOP: `o_play_restart` pulses and mode stays 3.
- Play key in IDLE with `o_have_data`=0 → no pulse, mode stays 0.
- In RECORD, stop and pause in the same cycle → only `o_rec_stop`, mode 0.
- `i_play_req` high during RECORD → never acked, `o_sram_oe_n` stays 1. Stop issued during P_ACCESS of a write → the write ack is still delivered.
- Write acked at address 20'hFFFFF → `o_rec_stop` pulses in the ack cycle and mode becomes 0. Reset asserted mid-access → no ack, strobes return to 1.
